seq_mult32: RTL and testbench

Sequential 32x32 radix-2 shift-add multiplier producing a 64-bit product, signed or unsigned. It sits directly upstream of the team's 64-bit Kogge-Stone adder (`koggestone64bit`) and time-shares one instance of it for every operation: absolute value, partial-product accumulation and final negation. A valid/ready handshake on both sides connects it to the microcontroller execute stage.

---
 rtl/seq_mult32.sv | 134 +++++++++++++
 tb/tb_seq_mult32.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult32.sv
// Sequential 32x32 radix-2 shift-add multiplier, signed or unsigned, 64-bit product.
// All arithmetic (abs value, accumulation, final negation) goes through one external 64-bit adder.
module seq_mult32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  output logic        add_cin,
  input  logic [63:0] add_s
);

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    MUL,
    FIX,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic        neg;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;

  assign in_ready = (state == IDLE);

  // Adder operand mux; the adder is idle (all-zero operands) in IDLE and DONE.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      ABS_A: begin
        if (sgn_q && a_q[31]) begin
          add_a   = {32'h0, ~a_q};
          add_cin = 1'b1;
        end else begin
          add_a   = {32'h0, a_q};
        end
      end
      ABS_B: begin
        if (sgn_q && b_q[31]) begin
          add_a   = {32'h0, ~b_q};
          add_cin = 1'b1;
        end else begin
          add_a   = {32'h0, b_q};
        end
      end
      MUL: begin
        add_a = acc;
        add_b = mplier[0] ? mcand : '0;
      end
      FIX: begin
        add_a   = neg ? ~acc : acc;
        add_cin = neg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= is_signed;
            neg   <= is_signed & (a[31] ^ b[31]);
            state <= ABS_A;
          end
        end
        ABS_A: begin
          mcand <= {32'h0, add_s[31:0]};
          state <= ABS_B;
        end
        ABS_B: begin
          mplier <= add_s[31:0];
          acc    <= '0;
          cnt    <= '0;
          state  <= MUL;
        end
        MUL: begin
          acc    <= add_s;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          product   <= add_s;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult32.sv
// Bench for seq_mult32: behavioural product/timing model, per-cycle compare, directed and random ops.
module tb_seq_mult32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stand-in for the combinational 64-bit adder.
  assign add_s = add_a + add_b + {63'd0, add_cin};

  seq_mult32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      return 64'(sx * sy);
    end
    return {32'h0, x} * {32'h0, y};
  endfunction

  function automatic logic [63:0] mag(input logic [31:0] x, input logic s);
    logic [31:0] n;
    n = 32'd0 - x;
    return (s && x[31]) ? {32'h0, n} : {32'h0, x};
  endfunction

  // Model: k counts edges since the accepting edge; k==35 means product presented.
  bit          busy = 0;
  int          k = 0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_s = 1'b0;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;
  logic        m_neg = 1'b0;
  logic [63:0] exp_p = '0;
  logic [63:0] last_prod = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (k < 35) begin
          k++;
          if (k == 35) last_prod = exp_p;
        end else if (out_ready) begin
          busy = 0;
        end
      end else if (in_valid) begin
        busy  = 1;
        k     = 0;
        op_a  = a;
        op_b  = b;
        op_s  = is_signed;
        m_a   = mag(a, is_signed);
        m_b   = mag(b, is_signed);
        m_neg = is_signed & (a[31] ^ b[31]);
        exp_p = ref_mul(a, b, is_signed);
      end
    end
  end

  always @(negedge rst_n) begin
    busy      = 0;
    k         = 0;
    last_prod = '0;
  end

  always @(negedge clk) begin
    logic [63:0] ea;
    logic [63:0] eb;
    logic        ec;
    logic [63:0] full;
    int          i;
    ea = '0;
    eb = '0;
    ec = 1'b0;
    if (busy && k == 0) begin
      ec = op_s & op_a[31];
      ea = ec ? {32'h0, ~op_a} : {32'h0, op_a};
    end else if (busy && k == 1) begin
      ec = op_s & op_b[31];
      ea = ec ? {32'h0, ~op_b} : {32'h0, op_b};
    end else if (busy && k >= 2 && k <= 33) begin
      i  = k - 2;
      ea = m_a * (m_b & ((64'd1 << i) - 64'd1));
      eb = m_b[i] ? (m_a << i) : 64'd0;
    end else if (busy && k == 34) begin
      full = m_a * m_b;
      ea   = m_neg ? ~full : full;
      ec   = m_neg;
    end
    chk("in_ready", {63'd0, in_ready}, {63'd0, !busy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, busy && k == 35});
    chk("product", product, last_prod);
    chk("add_a", add_a, ea);
    chk("add_b", add_b, eb);
    chk("add_cin", {63'd0, add_cin}, {63'd0, ec});
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s, input int hold,
                       input bit lit_on, input logic [63:0] lit, input string name);
    int          n;
    int          lat;
    logic [63:0] p0;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready_wait"}, {63'd0, in_ready}, 64'd1);
    #1;
    a = x; b = y; is_signed = s; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat - 1), 64'd35);
    if (lit_on) chk(name, product, lit);
    if (hold > 0) begin
      p0 = product;
      repeat (hold) begin
        @(negedge clk);
        chk({name, "_stall_prod"}, product, p0);
        chk({name, "_stall_ready"}, {63'd0, in_ready}, 64'd0);
        chk({name, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
        #1;
        in_valid = 1'b1; a = $urandom; b = $urandom;
      end
      #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk({name, "_release_ready"}, {63'd0, in_ready}, 64'd1);
      chk({name, "_release_valid"}, {63'd0, out_valid}, 64'd0);
      chk({name, "_release_prod"}, product, p0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    int          sel;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_prod", product, 64'd0);
    chk("reset_ready", {63'd0, in_ready}, 64'd1);
    #1 rst_n = 1'b1;

    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1, 64'hFFFFFFFE00000001, "u_max");
    do_op(32'hFFFFFFFD, 32'd5,        1'b1, 0, 1, 64'hFFFFFFFFFFFFFFF1, "s_m3x5");
    do_op(32'h80000000, 32'h80000000, 1'b1, 0, 1, 64'h4000000000000000, "s_min2");
    do_op(32'h80000000, 32'h80000000, 1'b0, 0, 1, 64'h4000000000000000, "u_min2");
    do_op(32'h80000000, 32'd1,        1'b1, 0, 1, 64'hFFFFFFFF80000000, "s_minx1");
    do_op(32'd0,        32'hFFFFFFFF, 1'b1, 0, 1, 64'd0,                "s_zero");
    do_op(32'h12345678, 32'd0,        1'b0, 0, 1, 64'd0,                "u_zero");
    do_op(32'd1000,     32'hFFFFFFFF, 1'b1, 10, 1, 64'hFFFFFFFFFFFFFC18, "bp_stall");

    // Abort mid-accumulation, then check a clean restart.
    @(negedge clk);
    #1;
    a = 32'h01234567; b = 32'h89ABCDEF; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    #1 in_valid = 1'b0;
    repeat (16) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_prod", product, 64'd0);
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_add_a", add_a, 64'd0);
    chk("midrst_add_b", add_b, 64'd0);
    chk("midrst_cin", {63'd0, add_cin}, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_op(32'd7, 32'd6, 1'b0, 0, 1, 64'd42, "after_rst");

    for (int t = 0; t < 1000; t++) begin
      x   = $urandom;
      y   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) x = 32'h80000000;
      if (sel == 1) y = 32'h80000000;
      if (sel == 2) x = 32'd0;
      if (sel == 3) y = 32'hFFFFFFFF;
      do_op(x, y, s, ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0, 0, 64'd0, "rnd");
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
